// File: rtl/temp_fan_ctrl.sv
// Purpose: hysteretic fan controller; samples temp once per SAMPLE_DIV cycles, confirms trends, drives PWM.
// Latency: one cycle from a sample_tick to the updated state/alarm; fan_pwm follows duty one cycle later.
// Backpressure: none; free-running block, enable=0 parks everything except the PWM counter.
//
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   temp[5:0]      - unsigned temperature in degrees C
//   enable         - controller enable; low forces fan off and restarts the sample divider
//   sample_tick    - one-cycle pulse in the cycle temp is sampled
//   fan_on         - fan requested (ON or HOLD)
//   fan_pwm        - registered PWM drive
//   alarm          - registered over-temperature flag
//   state[1:0]     - OFF=00, ARM=01, ON=10, HOLD=11
module temp_fan_ctrl #(
    parameter int         SAMPLE_DIV = 100000,
    parameter int         CONFIRM    = 4,
    parameter logic [5:0] T_ON       = 6'd27,
    parameter logic [5:0] T_OFF      = 6'd24,
    parameter logic [5:0] T_ALARM    = 6'd40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] temp,
    input  logic       enable,
    output logic       sample_tick,
    output logic       fan_on,
    output logic       fan_pwm,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]       CONF_N   = 4'(CONFIRM);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_ARM  = 2'b01,
        S_ON   = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       conf_q, conf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [5:0]       temp_q, temp_d;
    logic             alarm_q, alarm_d;
    logic             fan_pwm_q, fan_pwm_d;
    logic [3:0]       conf_inc;
    logic [4:0]       duty;

    assign sample_tick = enable && (div_q == DIV_LAST);
    assign fan_on      = (state_q == S_ON) || (state_q == S_HOLD);
    assign fan_pwm     = fan_pwm_q;
    assign alarm       = alarm_q;
    assign state       = state_q;
    assign conf_inc    = conf_q + 4'd1;

    // Duty is taken from registered state so the PWM never sees a mid-cycle decision.
    always_comb begin
        duty = 5'd0;
        if (alarm_q) begin
            duty = 5'd16;
        end else if (fan_on) begin
            if (temp_q <= 6'd31)      duty = 5'd8;
            else if (temp_q <= 6'd35) duty = 5'd12;
            else                      duty = 5'd16;
        end
    end

    always_comb begin
        state_d   = state_q;
        conf_d    = conf_q;
        div_d     = div_q;
        temp_d    = temp_q;
        alarm_d   = alarm_q;
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        fan_pwm_d = enable && ({1'b0, pwm_cnt_q} < duty);

        if (!enable) begin
            // Divider parks at 0, so re-enabling restarts a full sample period.
            state_d = S_OFF;
            conf_d  = 4'd0;
            div_d   = '0;
            alarm_d = 1'b0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (sample_tick) begin
                temp_d = temp;
                if (temp >= T_ALARM) begin
                    // Over-temperature overrides any pending confirmation.
                    alarm_d = 1'b1;
                    state_d = S_ON;
                    conf_d  = 4'd0;
                end else begin
                    alarm_d = 1'b0;
                    unique case (state_q)
                        S_OFF, S_ARM: begin
                            if (temp > T_ON) begin
                                // OFF holds conf_q=0, so conf_inc is 1 on the first hot sample.
                                if (conf_inc == CONF_N) begin
                                    state_d = S_ON;
                                    conf_d  = 4'd0;
                                end else begin
                                    state_d = S_ARM;
                                    conf_d  = conf_inc;
                                end
                            end else begin
                                state_d = S_OFF;
                                conf_d  = 4'd0;
                            end
                        end
                        S_ON, S_HOLD: begin
                            if (temp <= T_OFF) begin
                                if (conf_inc == CONF_N) begin
                                    state_d = S_OFF;
                                    conf_d  = 4'd0;
                                end else begin
                                    state_d = S_HOLD;
                                    conf_d  = conf_inc;
                                end
                            end else begin
                                state_d = S_ON;
                                conf_d  = 4'd0;
                            end
                        end
                        default: begin
                            state_d = S_OFF;
                            conf_d  = 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_OFF;
            conf_q    <= 4'd0;
            div_q     <= '0;
            pwm_cnt_q <= 4'd0;
            temp_q    <= 6'd0;
            alarm_q   <= 1'b0;
            fan_pwm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            conf_q    <= conf_d;
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            temp_q    <= temp_d;
            alarm_q   <= alarm_d;
            fan_pwm_q <= fan_pwm_d;
        end
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// Purpose: self-checking bench for temp_fan_ctrl with SAMPLE_DIV=4, CONFIRM=3.
// Latency: compares outputs 1ns after each rising edge against a cycle reference model.
// Backpressure: not applicable.
module tb_temp_fan_ctrl;

    localparam int SD = 4;
    localparam int CF = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] temp;
    logic       enable;
    logic       sample_tick, fan_on, fan_pwm, alarm;
    logic [1:0] state;

    temp_fan_ctrl #(.SAMPLE_DIV(SD), .CONFIRM(CF)) dut (
        .clk(clk), .reset(reset), .temp(temp), .enable(enable),
        .sample_tick(sample_tick), .fan_on(fan_on), .fan_pwm(fan_pwm),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 0=OFF 1=ARM 2=ON 3=HOLD
    int m_state, m_cnt, m_div, m_pwm, m_tempq;
    bit m_alarm, m_fanpwm, m_valid;
    logic last_tick;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int duty_of(input bit al, input int st, input int tq);
        if (al) return 16;
        if (st >= 2) return (tq <= 31) ? 8 : (tq <= 35) ? 12 : 16;
        return 0;
    endfunction

    task automatic model_edge(input int t, input bit e, input bit r);
        bit tick, hot, cool, nf;
        if (r) begin
            m_state = 0; m_cnt = 0; m_div = 0; m_pwm = 0; m_tempq = 0;
            m_alarm = 0; m_fanpwm = 0; m_valid = 1;
            return;
        end
        nf   = e && (m_pwm < duty_of(m_alarm, m_state, m_tempq));
        tick = e && (m_div == SD - 1);
        m_pwm = (m_pwm + 1) % 16;
        if (!e) begin
            m_state = 0; m_cnt = 0; m_div = 0; m_alarm = 0;
        end else begin
            m_div = (m_div + 1) % SD;
            if (tick) begin
                m_tempq = t;
                if (t >= 40) begin
                    m_alarm = 1; m_state = 2; m_cnt = 0;
                end else begin
                    m_alarm = 0;
                    hot  = (t > 27);
                    cool = (t <= 24);
                    if (m_state < 2) begin
                        if (hot) begin
                            m_cnt++;
                            if (m_cnt == CF) begin m_state = 2; m_cnt = 0; end
                            else m_state = 1;
                        end else begin
                            m_state = 0; m_cnt = 0;
                        end
                    end else begin
                        if (cool) begin
                            m_cnt++;
                            if (m_cnt == CF) begin m_state = 0; m_cnt = 0; end
                            else m_state = 3;
                        end else begin
                            m_state = 2; m_cnt = 0;
                        end
                    end
                end
            end
        end
        m_fanpwm = nf;
    endtask

    // One clock: drive inputs, check the combinational tick, clock, check registered outputs.
    task automatic cyc(input logic [5:0] t, input logic e, input logic r);
        temp = t; enable = e; reset = r;
        #1;
        last_tick = sample_tick;
        if (m_valid) chk("sample_tick", sample_tick, 8'(e && (m_div == SD - 1)));
        @(posedge clk);
        model_edge(int'(t), e, r);
        #1;
        chk("state",   state,   8'(m_state));
        chk("fan_on",  fan_on,  8'(m_state >= 2));
        chk("alarm",   alarm,   8'(m_alarm));
        chk("fan_pwm", fan_pwm, 8'(m_fanpwm));
    endtask

    task automatic run(input int n, input logic [5:0] t, input logic e);
        for (int i = 0; i < n; i++) cyc(t, e, 1'b0);
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cyc(temp, 1'b1, 1'b0);
            if (fan_pwm === 1'b1) highs++;
        end
    endtask

    initial begin
        int highs, first;
        int t_tab[10];
        int hold_n;
        logic [5:0] rt;
        logic re;
        t_tab = '{20, 24, 25, 27, 28, 30, 33, 36, 40, 45};
        m_valid = 0;
        temp = 6'd0; enable = 1'b0; reset = 1'b1;
        @(negedge clk);

        // Reset state
        cyc(6'd30, 1'b1, 1'b1);
        chk("reset_state", state, 8'h0);
        chk("reset_pwm", fan_pwm, 8'h0);

        // Sustained heat: OFF -> ARM -> ARM -> ON, then 50% PWM
        run(12, 6'd30, 1'b1);
        chk("heat_on", state, 8'h2);
        count_pwm(16, highs);
        chk("pwm8_highs", 8'(highs), 8'd8);

        // Confirmation aborted in ARM
        cyc(6'd0, 1'b1, 1'b1);
        run(8, 6'd30, 1'b1);
        chk("arm_mid", state, 8'h1);
        run(4, 6'd27, 1'b1);
        chk("arm_abort", state, 8'h0);
        chk("arm_abort_fan", fan_on, 8'h0);

        // HOLD returns to ON, then a full cool run turns the fan off
        cyc(6'd0, 1'b1, 1'b1);
        run(12, 6'd30, 1'b1);
        run(8, 6'd24, 1'b1);
        chk("hold", state, 8'h3);
        run(4, 6'd25, 1'b1);
        chk("hold_back_on", state, 8'h2);
        run(12, 6'd24, 1'b1);
        chk("cool_off", state, 8'h0);

        // Alarm from OFF, full duty, then release at 33 with duty 12
        cyc(6'd0, 1'b1, 1'b1);
        run(4, 6'd41, 1'b1);
        chk("alarm_state", state, 8'h2);
        chk("alarm_set", alarm, 8'h1);
        cyc(6'd41, 1'b1, 1'b0);
        count_pwm(16, highs);
        chk("pwm16_highs", 8'(highs), 8'd16);
        run(4, 6'd33, 1'b1);
        chk("alarm_clr", alarm, 8'h0);
        run(2, 6'd33, 1'b1);
        count_pwm(16, highs);
        chk("pwm12_highs", 8'(highs), 8'd12);

        // Reset in HOLD aborts to OFF
        cyc(6'd0, 1'b1, 1'b1);
        run(12, 6'd30, 1'b1);
        run(4, 6'd24, 1'b1);
        chk("pre_rst_hold", state, 8'h3);
        cyc(6'd24, 1'b1, 1'b1);
        chk("rst_hold", state, 8'h0);

        // Enable drop in ON (under alarm), then restart timing
        run(4, 6'd45, 1'b1);
        cyc(6'd45, 1'b0, 1'b0);
        chk("dis_state", state, 8'h0);
        chk("dis_pwm", fan_pwm, 8'h0);
        chk("dis_alarm", alarm, 8'h0);
        first = -1;
        for (int i = 0; i < 6; i++) begin
            cyc(6'd30, 1'b1, 1'b0);
            if (last_tick === 1'b1 && first < 0) first = i;
        end
        chk("first_tick_idx", 8'(first), 8'd3);

        // Randomized soak
        for (int k = 0; k < 150; k++) begin
            rt = 6'(t_tab[$urandom_range(0, 9)]);
            hold_n = $urandom_range(1, 8);
            for (int j = 0; j < hold_n; j++) begin
                re = ($urandom_range(0, 29) != 0);
                cyc(rt, re, 1'b0);
            end
            if ($urandom_range(0, 99) == 0) cyc(rt, 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/temp_fan_ctrl.md
TEMP_FAN_CTRL -- requirements
Module: temp_fan_ctrl

Interface
REQ-001 SHALL provide parameter SAMPLE_DIV, default 100000: clock cycles per temperature sample; legal range 2..2^20.
REQ-002 SHALL provide parameter CONFIRM, default 4: consecutive qualifying samples needed to change fan state; legal range 1..15.
REQ-003 SHALL provide parameter T_ON, default 6'd27: fan-on threshold; qualifies when temp > T_ON.
REQ-004 SHALL provide parameter T_OFF, default 6'd24: fan-off threshold; qualifies when temp <= T_OFF; T_OFF < T_ON.
REQ-005 SHALL provide parameter T_ALARM, default 6'd40: over-temperature threshold; alarm when temp >= T_ALARM.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 temp  input  6  unsigned temperature in degrees C.
REQ-009 enable  input  1  controller enable; low forces fan off.
REQ-010 sample_tick  output  1  one-cycle pulse marking the cycle in which temp is sampled.
REQ-011 fan_on  output  1  fan requested (state ON or HOLD).
REQ-012 fan_pwm  output  1  PWM drive to the fan.
REQ-013 alarm  output  1  registered over-temperature flag.
REQ-014 state  output  2  current FSM state: OFF=00, ARM=01, ON=10, HOLD=11.

Function
REQ-015 SHALL have a divider counter that counts 0..SAMPLE_DIV-1 and wraps to 0.
REQ-016 SHALL assert sample_tick combinationally when divider == SAMPLE_DIV-1 and enable=1.
REQ-017 SHALL make all decisions on sample_tick cycles only, using temp in that cycle; effects SHALL be visible after that clock edge (1-cycle latency).
REQ-018 SHALL capture temp into temp_q on each sample_tick.
REQ-019 SHALL, in OFF, on a sample with temp > T_ON, go to ARM with conf_cnt=1; if CONFIRM=1, go directly to ON instead.
REQ-020 SHALL, in ARM, on a sample with temp > T_ON, increment conf_cnt and go to ON when the new count equals CONFIRM; on temp <= T_ON, go to OFF with conf_cnt=0.
REQ-021 SHALL, in ON, on a sample with temp <= T_OFF, go to HOLD with conf_cnt=1; if CONFIRM=1, go directly to OFF instead.
REQ-022 SHALL, in HOLD, on a sample with temp <= T_OFF, increment conf_cnt and go to OFF when the new count equals CONFIRM; on temp > T_OFF, return to ON with conf_cnt=0.
REQ-023 SHALL clear conf_cnt on every entry to OFF or ON.
REQ-024 SHALL drive fan_on = (state==ON or state==HOLD), decoded from registered state.
REQ-025 SHALL, on a sample with temp >= T_ALARM, set alarm=1 and force state=ON with conf_cnt=0 from any state; this takes priority over REQ-019..REQ-022.
REQ-026 SHALL clear alarm on a sample with temp < T_ALARM.
REQ-027 SHALL run a free-running 4-bit pwm_cnt, wrapping 15->0, and SHALL compute a 5-bit duty.
REQ-028 SHALL set duty=16 when alarm=1; otherwise, when fan_on, duty=8 for temp_q <= 31, 12 for 32..35, and 16 for >= 36; otherwise duty=0.
REQ-029 SHALL register fan_pwm = (pwm_cnt < duty); duty 16 gives a constant 1 and duty 0 gives a constant 0.
REQ-030 SHALL, when enable=0, on the next edge force state=OFF, clear conf_cnt, divider, alarm and fan_pwm, and hold them there; pwm_cnt keeps running.
REQ-031 SHALL, when enable rises, restart the divider from 0, so the first sample_tick follows SAMPLE_DIV cycles later.

Reset
REQ-032 SHALL, while reset=1 at a clk edge, set state=OFF, conf_cnt=0, divider=0, pwm_cnt=0, temp_q=0, alarm=0 and fan_pwm=0; sample_tick and fan_on are therefore 0.
REQ-033 SHALL give reset priority over enable and alarm, including mid-confirmation (ARM or HOLD), which aborts to OFF.

Verification (SAMPLE_DIV=4, CONFIRM=3, defaults otherwise)
REQ-034 temp=30 held after reset -> sample_tick every 4th cycle; state OFF->ARM->ARM->ON on ticks 1-3; fan_on=1 after tick 3; fan_pwm high 8 of 16 cycles.
REQ-035 In ARM, temp goes 30,30,27 over three ticks -> state returns to OFF on the 27 sample; fan_on stays 0.
REQ-036 In ON, temp=24 for two ticks then 25 -> state ON->HOLD->HOLD->ON; with temp=24 for three ticks -> OFF.
REQ-037 In OFF, temp=41 for one tick -> state=ON and alarm=1 after that edge, fan_pwm constantly 1; then temp=33 -> alarm=0, duty 12.
REQ-038 Assert reset in HOLD, and separately drop enable in ON -> next edge gives state=OFF, fan_pwm=0 and alarm=0; after enable rises, the first tick follows 4 cycles later.
